// File: rtl/crc32_pkg.sv
// Shared CRC-32 definitions for the 32-bit word datapath.
// Holds the polynomial, init and residue constants, the transmitter state
// encoding and the 32-bit parallel update used by both the transmitter and
// the receive-side checker.
package crc32_pkg;

   localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_RESIDUE = 32'h00000000;

   typedef enum logic {
      ST_DATA,
      ST_CRC
   } crc32_state_t;

   // Non-reflected, MSB-first update of the CRC register by one 32-bit word.
   // The loop unrolls into a pure XOR network. Its net effect is
   // (c ^ d) * x^32 mod P, so running the raw register value back through
   // the update yields a zero residue.
   function automatic logic [31:0] crc32_d32_next(input logic [31:0] c,
                                                  input logic [31:0] d);
      logic [31:0] r;
      logic        fb;
      r = c;
      for (int i = 31; i >= 0; i--) begin
         fb = r[31] ^ d[i];
         r  = {r[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0);
      end
      return r;
   endfunction

endpackage

// File: rtl/crc32_d32_next_comb.sv
// Combinational CRC-32 word update, a thin wrapper around the package
// function so the XOR network appears as its own instance.
// Ports:
//   c  current CRC register value
//   d  data word being absorbed
//   n  next CRC register value
module crc32_d32_next_comb
   import crc32_pkg::*;
(
   input  logic [31:0] c,
   input  logic [31:0] d,
   output logic [31:0] n
);

   assign n = crc32_d32_next(c, d);

endmodule

// File: rtl/crc32_append_tx.sv
// Transmit-side CRC-32 generator. Forwards every word of an input frame
// unchanged and appends the raw CRC register as one extra beat after the
// word marked s_last.
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   s_valid/s_ready/s_data/s_last input word stream
//   m_valid/m_ready/m_data        output beat stream
//   m_last, m_is_crc              both high only on the appended CRC beat
//   busy                          frame in progress until CRC beat accepted
module crc32_append_tx
   import crc32_pkg::*;
#(
   parameter logic [31:0] CRC_INIT = CRC32_INIT
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [31:0] s_data,
   input  logic        s_last,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [31:0] m_data,
   output logic        m_last,
   output logic        m_is_crc,
   output logic        busy
);

   crc32_state_t state;
   logic [31:0]  crc;
   logic [31:0]  crc_next;
   logic         out_free;

   crc32_d32_next_comb u_crc_next (
      .c (crc),
      .d (s_data),
      .n (crc_next)
   );

   // The output register can take a new beat when it is empty or its
   // current beat is being consumed this cycle. s_ready depends only on
   // registered state and m_ready, never on s_valid.
   assign out_free = !m_valid || m_ready;
   assign s_ready  = (state == ST_DATA) && out_free;

   // FSM, CRC register, output register and busy flag. A consumed beat
   // drops m_valid unless a new beat is loaded on the same edge; fields
   // otherwise hold, keeping the output stable while stalled. The busy
   // clear comes before the data accept so that a new frame starting on
   // the CRC handshake edge leaves busy set.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_DATA;
         crc      <= CRC_INIT;
         m_valid  <= 1'b0;
         m_data   <= 32'h0;
         m_last   <= 1'b0;
         m_is_crc <= 1'b0;
         busy     <= 1'b0;
      end else begin
         if (m_valid && m_ready) begin
            m_valid <= 1'b0;
         end
         if (m_valid && m_ready && m_is_crc) begin
            busy <= 1'b0;
         end
         case (state)
            ST_DATA: begin
               if (s_valid && s_ready) begin
                  m_data   <= s_data;
                  m_valid  <= 1'b1;
                  m_last   <= 1'b0;
                  m_is_crc <= 1'b0;
                  crc      <= crc_next;
                  busy     <= 1'b1;
                  if (s_last) begin
                     state <= ST_CRC;
                  end
               end
            end
            ST_CRC: begin
               if (out_free) begin
                  m_data   <= crc;
                  m_valid  <= 1'b1;
                  m_last   <= 1'b1;
                  m_is_crc <= 1'b1;
                  crc      <= CRC_INIT;
                  state    <= ST_DATA;
               end
            end
            default: begin
               state <= ST_DATA;
            end
         endcase
      end
   end

endmodule

// File: doc/crc32_append_tx.md
# crc32_append_tx

Transmit-side CRC-32 generator for the 32-bit word datapath. Accepts a frame of 32-bit words on a valid/ready input stream, forwards each word unchanged, and appends one CRC word after the frame's last word. A downstream CRC-32 checker that runs all received words (data plus CRC) through the same update must reach a residue of 0x00000000.

## Interface
- `CRC_INIT`, default 32'hFFFFFFFF: CRC register value at reset and at the start of every frame.
- `clk`  in  1  clock; all logic is clocked on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  block can accept an input word this cycle.
- `s_data`  in  32  input frame word.
- `s_last`  in  1  marks the final data word of the frame; sampled only with `s_valid && s_ready`.
- `m_valid`  out  1  output beat valid.
- `m_ready`  in  1  downstream accepts the output beat.
- `m_data`  out  32  output word: forwarded data, or the CRC word.
- `m_last`  out  1  high only on the CRC beat, which is the last beat of the output frame.
- `m_is_crc`  out  1  high on the CRC beat, so the checker can flag it.
- `busy`  out  1  high while a frame is in progress, from the first accepted word until the CRC beat is accepted.

## Operation
- Polynomial 0x04C11DB7 with the team's 32-bit parallel update (`crc32_d32_next(c, d)`): non-reflected, no final XOR. The appended word is the raw CRC register.
- States:
  - ST_DATA: forwarding data words.
  - ST_CRC: the CRC word is waiting for the output register.
- Output register (`m_data`, `m_valid`, `m_last`, `m_is_crc`) is free when `!m_valid || m_ready`.
- `s_ready = (state == ST_DATA) && out_free`. No combinational path from `s_valid` to `s_ready`.
- Accept in ST_DATA (`s_valid && s_ready`):
  - load `m_data <= s_data`, `m_valid <= 1`, `m_last <= 0`, `m_is_crc <= 0`;
  - update `crc <= crc32_d32_next(crc, s_data)`;
  - set `busy <= 1`;
  - if `s_last`, go to ST_CRC.
- ST_CRC with `out_free`:
  - load `m_data <= crc`, `m_valid <= 1`, `m_last <= 1`, `m_is_crc <= 1`;
  - reset `crc <= CRC_INIT` and return to ST_DATA.
- `busy` clears when the CRC beat handshakes (`m_valid && m_ready && m_is_crc`).
- Output stays valid without a new load: if the register is not free, `m_*` hold their values (AXI-style stability: no change while `m_valid && !m_ready`).
- Frame lengths from 1 word upward. There is no length limit and no internal counter wrap.

## Timing
- Reset values:
  - `m_valid` 0, `m_data` 0, `m_last` 0, `m_is_crc` 0, `busy` 0;
  - `crc` = `CRC_INIT`, state ST_DATA;
  - `s_ready` is 1 in the first cycle after reset is released.
- Data latency: a word accepted at edge k is presented on `m_data` from edge k onward, i.e. it is visible in cycle k+1.
- CRC latency: last data word accepted at edge k. With `m_ready` high, the CRC beat is loaded at edge k+1. `s_ready` is 0 in the cycle between edges k and k+1.
- Throughput with `m_ready` held high: N data words give N+1 output beats in N+1 consecutive cycles. The first word of the next frame can be accepted at the edge after the CRC load, with no extra bubble.
- Backpressure during ST_CRC: the CRC word waits, `s_ready` stays 0, and `crc` is unchanged.
- Frames arriving while `m_ready` is low are held by `s_ready = 0`. No data is dropped or duplicated.
- Reset mid-frame: all state returns to reset values and the partial frame is discarded. No CRC beat is emitted for it.

## Structure
- Shared package `crc32_pkg` holds:
  - `CRC32_POLY` (32'h04C11DB7);
  - `CRC32_INIT` (32'hFFFFFFFF);
  - `CRC32_RESIDUE` (32'h00000000);
  - the state enum {ST_DATA, ST_CRC};
  - function `crc32_d32_next(c, d)` holding the XOR equations, shared with the checker.
- One combinational sub-module is natural: `crc32_d32_next_comb` (inputs `c[31:0]`, `d[31:0]`; output `n[31:0]`), a wrapper around the package function.
- Top level: FSM, CRC register, output register, busy flag.

## Test plan
- Reset: hold `rst_n` low for 3 cycles.
  - During reset: `m_valid` = 0, `busy` = 0.
  - After release: `s_ready` = 1, internal `crc` = 0xFFFFFFFF.
- Frame 0x00000001..0x00000008, `s_last` on the 8th word, `m_ready` = 1:
  - 9 output beats in 9 consecutive cycles; beats 1–8 equal the input words;
  - beat 9 has `m_last` = 1 and `m_is_crc` = 1;
  - running `crc32_d32_next` over all 9 words from 0xFFFFFFFF gives 0x00000000.
- Single-word frame 0xDEADBEEF with `s_last` = 1:
  - 2 beats; the CRC beat equals `crc32_d32_next(0xFFFFFFFF, 0xDEADBEEF)`;
  - residue over the 2 beats is 0.
- Random `m_ready` (50 %) over three back-to-back frames of lengths 1, 4 and 8:
  - `m_*` stable while stalled;
  - exactly 3 CRC beats, each with residue 0;
  - the second frame's CRC is identical to a standalone run, proving re-init to 0xFFFFFFFF.
- Reset mid-frame, after 3 of 8 words are accepted:
  - no CRC beat; `busy` = 0;
  - a following frame 0x00000001..0x00000008 produces the same CRC as in the second scenario.
- Hold `m_ready` = 0 with the CRC pending for 10 cycles:
  - `s_ready` = 0 and `m_data` stays equal to the CRC throughout;
  - when `m_ready` is raised, the CRC beat handshakes in 1 cycle and `busy` falls.
